// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail transmitter: FSM state type and the
// spacer (all-rails-low) constant helper.
package dr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_SPACER = 2'd2
  } dr_tx_state_t;

  localparam int DR_MAX_WIDTH = 4096;

  // Spacer is all-zero on both rails; callers size-cast to their own WIDTH.
  function automatic logic [DR_MAX_WIDTH-1:0] dr_spacer();
    return '0;
  endfunction

endpackage

// File: rtl/dr_sync.sv
// Reset-to-zero flop chain bringing the asynchronous dual-rail acknowledge
// into the clk domain. STAGES must be at least 2.
module dr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dr_sync_tx.sv
// Clocked-to-dual-rail 4-phase RZ transmitter. Optional ack watchdog with a
// sticky timeout_err flag is built when DR_TX_ACK_TIMEOUT_EN is defined.
module dr_sync_tx
  import dr_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] tx_t,
  output logic [WIDTH-1:0] tx_f,
  input  logic             tx_ack,
  output logic             busy,
`ifdef DR_TX_ACK_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output dr_tx_state_t     dbg_state_o
);

  localparam logic [WIDTH-1:0] SPACER = WIDTH'(dr_spacer());
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  // Handshake: a word moves when in_valid && in_ready are both high at a
  // rising edge; in_valid with in_ready low is ignored and the source holds.
  dr_tx_state_t      state_q, state_d;
  logic [WIDTH-1:0]  tx_t_q, tx_t_d, tx_f_q, tx_f_d;
  logic [WARM_W-1:0] warm_q;
  logic              warm_done;
  logic              ack_s;

  dr_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (tx_ack),
    .q_o (ack_s)
  );

  // The synchronizer restarts at 0 after reset, so ack_s only reflects the
  // real tx_ack once the chain has refilled; hold off acceptance until then.
  assign warm_done = (warm_q == WARM_W'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_t_q  <= SPACER;
      tx_f_q  <= SPACER;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      tx_t_q  <= tx_t_d;
      tx_f_q  <= tx_f_d;
      if (!warm_done) warm_q <= warm_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid && in_ready) state_d = ST_DATA;
      ST_DATA:   if (ack_s)                state_d = ST_SPACER;
      ST_SPACER: if (!ack_s)               state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Rails are computed from the next state so every rail switches on the
  // same edge straight out of a flop.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && !ack_s && warm_done && !rst;
    busy     = (state_q != ST_IDLE);
    tx_t_d   = tx_t_q;
    tx_f_d   = tx_f_q;
    if (state_d == ST_DATA) begin
      if (state_q != ST_DATA) begin
        tx_t_d = in_data;
        tx_f_d = ~in_data;
      end
    end else begin
      tx_t_d = SPACER;
      tx_f_d = SPACER;
    end
  end

  assign tx_t        = tx_t_q;
  assign tx_f        = tx_f_q;
  assign dbg_state_o = state_q;

`ifdef DR_TX_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // Counter holds the number of cycles spent in the current wait state.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (state_d == ST_IDLE)                          to_cnt_d = '0;
    else if (state_d != state_q)                     to_cnt_d = TO_W'(1);
    else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES))      to_cnt_d = to_cnt_q + 1'b1;
    if (state_d != ST_IDLE && to_cnt_d == TO_W'(TIMEOUT_CYCLES)) to_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`endif

endmodule
